pkt_gen_axis: RTL

Parametrised successor to the single-width Ethernet packet builder. It accepts frame commands over a valid/ready handshake: size, destination/source MAC, ethertype, payload seed and payload mode. For each command it emits one complete Ethernet frame on an AXI-Stream master with full `tready` backpressure. Data width is generic (the 14-byte header may span several beats), payload may be fixed or incrementing, and a programmable inter-frame gap and a frame counter are provided. It sits between the command FIFO and the MAC TX stream.

---
 rtl/pkt_gen_axis.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/pkt_gen_axis.sv
// Ethernet frame generator: turns one command into one AXI-Stream frame of
// generic width, with fixed or incrementing payload and an optional inter-frame gap.
module pkt_gen_axis #(
  parameter int DATA_WIDTH = 64,
  parameter int MIN_SIZE   = 14,
  parameter int IFG_CYCLES = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [10:0]             cmd_size,
  input  logic [47:0]             cmd_d_mac,
  input  logic [47:0]             cmd_s_mac,
  input  logic [15:0]             cmd_ethertype,
  input  logic [7:0]              cmd_payload,
  input  logic                    cmd_mode,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [31:0]             frame_count,
  output logic                    busy
);

  localparam int N     = DATA_WIDTH / 8;
  localparam int LOG2N = $clog2(N);
  localparam int REMW  = LOG2N + 1;
  localparam logic [10:0] MIN_L = 11'(MIN_SIZE);
  localparam logic [7:0]  IFG   = 8'(IFG_CYCLES);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t          state;
  logic [127:0]    hdr;
  logic [7:0]      payload;
  logic            mode;
  logic [15:0]     beat;
  logic [15:0]     last_beat;
  logic [N-1:0]    keep_last;
  logic [7:0]      gap_cnt;

  logic [10:0]     eff_len;
  logic [15:0]     n_beats;
  logic [REMW-1:0] rem;
  logic [N-1:0]    keep_calc;
  logic [DATA_WIDTH-1:0] beat_data;
  logic [15:0]     k;
  logic [7:0]      b;

  always_comb begin
    eff_len = (cmd_size < MIN_L) ? MIN_L : cmd_size;
    n_beats = (16'(eff_len) + 16'(N - 1)) >> LOG2N;
    rem     = (eff_len[LOG2N-1:0] == '0) ? REMW'(N) : REMW'(eff_len[LOG2N-1:0]);
    keep_calc = '0;
    for (int unsigned j = 0; j < N; j++)
      keep_calc[j] = (REMW'(j) < rem);
  end

  // Beat contents are generated from the beat index; header bytes come from a
  // little-endian packed copy of {ethertype, s_mac, d_mac}.
  always_comb begin
    beat_data = '0;
    k = '0;
    b = '0;
    for (int unsigned j = 0; j < N; j++) begin
      k = (beat << LOG2N) + 16'(j);
      if (k < 16'd14)
        b = hdr[{k[3:0], 3'b000} +: 8];
      else if (mode)
        b = payload + 8'(k - 16'd14);
      else
        b = payload;
      beat_data[8*j +: 8] = b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cmd_ready     <= 1'b0;
      busy          <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tkeep  <= '0;
      m_axis_tdata  <= '0;
      frame_count   <= '0;
      hdr           <= '0;
      payload       <= '0;
      mode          <= 1'b0;
      beat          <= '0;
      last_beat     <= '0;
      keep_last     <= '0;
      gap_cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            hdr       <= {16'h0000, cmd_ethertype, cmd_s_mac, cmd_d_mac};
            payload   <= cmd_payload;
            mode      <= cmd_mode;
            beat      <= '0;
            last_beat <= n_beats - 16'd1;
            keep_last <= keep_calc;
            state     <= SEND;
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
          end else begin
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        SEND: begin
          // The first load happens one cycle after acceptance, then one load per handshake.
          if (!m_axis_tvalid || (m_axis_tready && !m_axis_tlast)) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= beat_data;
            m_axis_tlast  <= (beat == last_beat);
            m_axis_tkeep  <= (beat == last_beat) ? keep_last : '1;
            beat          <= beat + 16'd1;
          end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            frame_count   <= frame_count + 32'd1;
            if (IFG != 8'd0) begin
              state   <= GAP;
              gap_cnt <= IFG;
            end else begin
              state     <= IDLE;
              busy      <= 1'b0;
              cmd_ready <= 1'b1;
            end
          end
        end
        GAP: begin
          if (gap_cnt == 8'd1) begin
            state     <= IDLE;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
